// File: rtl/axi_gran_burst_splitter_ax_chan_pkg.sv
// Shared types for the granular burst splitter AX channel: AXI field types,
// burst encodings, address alignment helper and the splitter FSM states.
package axi_gran_burst_splitter_ax_chan_pkg;

    localparam int unsigned AxAddrWidth = 32;
    localparam int unsigned AxIdWidth   = 4;

    typedef logic [7:0] len_t;
    typedef logic [2:0] size_t;
    typedef logic [1:0] burst_t;

    localparam burst_t BURST_FIXED = 2'b00;
    localparam burst_t BURST_INCR  = 2'b01;
    localparam burst_t BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic [AxIdWidth-1:0]   id;
        logic [AxAddrWidth-1:0] addr;
        len_t                   len;
        size_t                  size;
        burst_t                 burst;
        logic                   lock;
        logic [3:0]             cache;
        logic [2:0]             prot;
        logic [3:0]             qos;
    } ax_chan_t;

    typedef enum logic {
        IDLE,
        SPLIT
    } split_state_e;

    function automatic logic [63:0] aligned_addr(input logic [63:0] addr, input size_t size);
        return (addr >> size) << size;
    endfunction

endpackage

// File: rtl/axi_gran_burst_splitter_ax_chan.sv
// AX-channel front end of the granular burst splitter: allocates an ordering
// counter per accepted burst and re-issues it as sub-bursts of at most gran+1 beats.
module axi_gran_burst_splitter_ax_chan
    import axi_gran_burst_splitter_ax_chan_pkg::*;
#(
    parameter int unsigned AddrWidth = AxAddrWidth,
    parameter int unsigned IdWidth   = AxIdWidth,
    parameter type         ax_t      = ax_chan_t
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [7:0]         gran_i,
    input  ax_t                ax_i,
    input  logic               ax_valid_i,
    output logic               ax_ready_o,
    output ax_t                ax_o,
    output logic               ax_valid_o,
    input  logic               ax_ready_i,
    output logic [IdWidth-1:0] alloc_id_o,
    output logic [7:0]         alloc_len_o,
    output logic               alloc_req_o,
    input  logic               alloc_gnt_i
);

    split_state_e state_q, state_d;
    ax_t          ax_q, ax_d;
    logic [7:0]   rem_q, rem_d;
    logic [7:0]   gran_q, gran_d;
    logic [15:0]  addr_step;
    logic         last_sub;

    assign alloc_id_o  = IdWidth'(ax_i.id);
    assign alloc_len_o = ax_i.len;
    assign last_sub    = (rem_q <= gran_q);
    // gran_q < 255 whenever a step is taken, so gran_q+1 never wraps here
    assign addr_step   = (16'(gran_q) + 16'd1) << ax_q.size;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ax_q    <= '0;
            rem_q   <= '0;
            gran_q  <= '0;
        end else begin
            state_q <= state_d;
            ax_q    <= ax_d;
            rem_q   <= rem_d;
            gran_q  <= gran_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ax_d    = ax_q;
        rem_d   = rem_q;
        gran_d  = gran_q;
        unique case (state_q)
            IDLE: begin
                if (ax_valid_i && alloc_gnt_i) begin
                    state_d = SPLIT;
                    ax_d    = ax_i;
                    rem_d   = ax_i.len;
                    // wrapping or non-modifiable bursts must pass through whole
                    if (ax_i.burst == BURST_WRAP || !ax_i.cache[1]) begin
                        gran_d = 8'hFF;
                    end else begin
                        gran_d = gran_i;
                    end
                end
            end
            SPLIT: begin
                if (ax_ready_i) begin
                    if (last_sub) begin
                        state_d = IDLE;
                    end else begin
                        rem_d = rem_q - gran_q - 8'd1;
                        if (ax_q.burst == BURST_INCR) begin
                            ax_d.addr = AddrWidth'(aligned_addr(64'(ax_q.addr), ax_q.size))
                                      + AddrWidth'(addr_step);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ax_o        = ax_q;
        ax_o.len    = last_sub ? rem_q : gran_q;
        ax_valid_o  = 1'b0;
        ax_ready_o  = 1'b0;
        alloc_req_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                alloc_req_o = ax_valid_i;
                ax_ready_o  = ax_valid_i & alloc_gnt_i;
            end
            SPLIT:   ax_valid_o = 1'b1;
            default: ax_valid_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_axi_gran_burst_splitter_ax_chan.sv
// Self-checking bench for the splitter AX channel against a queue-based model
// that derives every sub-burst directly from the original burst and sampled gran.
module tb_axi_gran_burst_splitter_ax_chan;
    import axi_gran_burst_splitter_ax_chan_pkg::*;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic [7:0] gran_i;
    ax_chan_t   ax_i, ax_o;
    logic       ax_valid_i, ax_ready_o, ax_valid_o, ax_ready_i;
    logic [3:0] alloc_id_o;
    logic [7:0] alloc_len_o;
    logic       alloc_req_o, alloc_gnt_i;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    axi_gran_burst_splitter_ax_chan #(
        .AddrWidth(32),
        .IdWidth  (4),
        .ax_t     (ax_chan_t)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .gran_i     (gran_i),
        .ax_i       (ax_i),
        .ax_valid_i (ax_valid_i),
        .ax_ready_o (ax_ready_o),
        .ax_o       (ax_o),
        .ax_valid_o (ax_valid_o),
        .ax_ready_i (ax_ready_i),
        .alloc_id_o (alloc_id_o),
        .alloc_len_o(alloc_len_o),
        .alloc_req_o(alloc_req_o),
        .alloc_gnt_i(alloc_gnt_i)
    );

    // Sub-burst k covers beats [k*(g+1), ...]; its address is the aligned start plus
    // k*(g+1) beats, except the first which keeps the original (possibly unaligned) address.
    function automatic void build_exp(input ax_chan_t a, input logic [7:0] g_in, output ax_chan_t q[$]);
        int unsigned g, beats, done, n, k;
        logic [31:0] base;
        ax_chan_t s;
        q = {};
        g = (a.burst == BURST_WRAP || !a.cache[1]) ? 255 : int'(g_in);
        beats = int'(a.len) + 1;
        done = 0;
        k = 0;
        base = (a.addr >> a.size) << a.size;
        while (done < beats) begin
            n = (beats - done < g + 1) ? beats - done : g + 1;
            s = a;
            s.len = 8'(n - 1);
            if (k > 0 && a.burst == BURST_INCR) s.addr = base + ((k * (g + 1)) << a.size);
            q.push_back(s);
            done += n;
            k++;
        end
    endfunction

    function automatic ax_chan_t rand_ax(input burst_t b, input logic [3:0] cache);
        ax_chan_t a;
        a.id    = 4'($urandom);
        a.len   = 8'($urandom_range(0, 31));
        a.size  = 3'($urandom_range(0, 3));
        a.addr  = {20'($urandom), 12'($urandom_range(0, 4096 - 256 - 1))};
        a.burst = b;
        a.lock  = 1'($urandom);
        a.cache = cache;
        a.prot  = 3'($urandom);
        a.qos   = 4'($urandom);
        return a;
    endfunction

    task automatic run_burst(input ax_chan_t a, input logic [7:0] g, input int unsigned gnt_delay,
                             input bit rnd_ready, input bit rnd_gran, input int abort_at, input string tag);
        ax_chan_t    exp_q[$];
        int unsigned k = 0;
        int unsigned cyc = 0;
        build_exp(a, g, exp_q);
        @(posedge clk); #1;
        ax_i = a; gran_i = g; ax_valid_i = 1'b1; alloc_gnt_i = 1'b0; ax_ready_i = 1'b0;
        for (int i = 0; i < int'(gnt_delay); i++) begin
            #1;
            total++;
            if (ax_ready_o !== 1'b0 || ax_valid_o !== 1'b0 || alloc_req_o !== 1'b1) begin
                bad++;
                $display("FAIL %s gnt_wait%0d ready=%b valid=%b req=%b exp 0/0/1", tag, i, ax_ready_o, ax_valid_o, alloc_req_o);
            end
            @(posedge clk); #1;
        end
        alloc_gnt_i = 1'b1;
        #1;
        total++;
        if (ax_ready_o !== 1'b1 || alloc_req_o !== 1'b1 || alloc_len_o !== a.len || alloc_id_o !== a.id) begin
            bad++;
            $display("FAIL %s accept ready=%b req=%b len=%h id=%h exp 1/1/%h/%h", tag, ax_ready_o, alloc_req_o, alloc_len_o, alloc_id_o, a.len, a.id);
        end
        @(posedge clk); #1;
        ax_valid_i  = 1'b0;
        alloc_gnt_i = 1'($urandom);
        ax_i        = ax_chan_t'({$urandom, $urandom});
        while (k < exp_q.size() && cyc < 1000) begin
            if (abort_at >= 0 && k == unsigned'(abort_at)) return;
            ax_ready_i = rnd_ready ? 1'($urandom) : 1'b1;
            if (rnd_gran) gran_i = 8'($urandom);
            #1;
            total++;
            if (ax_valid_o !== 1'b1 || ax_ready_o !== 1'b0 || alloc_req_o !== 1'b0) begin
                bad++;
                $display("FAIL %s split_hs sub%0d valid=%b ready=%b req=%b exp 1/0/0", tag, k, ax_valid_o, ax_ready_o, alloc_req_o);
            end
            total++;
            if (ax_o !== exp_q[k]) begin
                bad++;
                $display("FAIL %s sub%0d ax_o got=%h exp=%h", tag, k, ax_o, exp_q[k]);
            end
            if (ax_valid_o === 1'b1 && ax_ready_i) k++;
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (cyc >= 1000) begin
            bad++;
            $display("FAIL %s timeout subs_seen=%0d exp=%0d", tag, k, exp_q.size());
        end
        ax_ready_i = 1'b0;
        alloc_gnt_i = 1'b0;
        #1;
        total++;
        if (ax_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL %s after_last valid=%b exp 0", tag, ax_valid_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; ax_valid_i = 1'b0; alloc_gnt_i = 1'b0; ax_ready_i = 1'b0;
        gran_i = '0; ax_i = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (ax_valid_o !== 1'b0 || ax_ready_o !== 1'b0 || alloc_req_o !== 1'b0 || ax_o !== '0) begin
            bad++;
            $display("FAIL reset_idle valid=%b ready=%b req=%b ax_o=%h exp 0/0/0/0", ax_valid_o, ax_ready_o, alloc_req_o, ax_o);
        end
        ax_valid_i = 1'b1;
        #1;
        total++;
        if (alloc_req_o !== 1'b1 || ax_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_req req=%b ready=%b exp 1/0", alloc_req_o, ax_ready_o);
        end
        ax_valid_i = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_incr_aligned();
        ax_chan_t a = rand_ax(BURST_INCR, 4'b0011);
        a.len = 8'd15; a.size = 3'd2; a.addr = 32'h0000_0100;
        run_burst(a, 8'd3, 0, 1'b0, 1'b0, -1, "incr_aligned");
    endtask

    task automatic test_incr_unaligned();
        ax_chan_t a = rand_ax(BURST_INCR, 4'b1010);
        a.len = 8'd9; a.size = 3'd3; a.addr = 32'h0000_0104;
        run_burst(a, 8'd3, 0, 1'b0, 1'b0, -1, "incr_unaligned");
    endtask

    task automatic test_no_split();
        ax_chan_t a = rand_ax(BURST_WRAP, 4'b0010);
        a.len = 8'd7;
        run_burst(a, 8'd1, 0, 1'b0, 1'b0, -1, "wrap");
        a = rand_ax(BURST_INCR, 4'b0001);
        a.len = 8'd20;
        run_burst(a, 8'd2, 0, 1'b0, 1'b0, -1, "non_modifiable");
        a = rand_ax(BURST_INCR, 4'b0010);
        run_burst(a, 8'd255, 0, 1'b0, 1'b0, -1, "gran_255");
        a = rand_ax(BURST_FIXED, 4'b0010);
        a.len = 8'd6;
        run_burst(a, 8'd1, 0, 1'b0, 1'b0, -1, "fixed");
    endtask

    task automatic test_grant_delay();
        ax_chan_t a = rand_ax(BURST_INCR, 4'b0010);
        run_burst(a, 8'd4, 5, 1'b0, 1'b0, -1, "grant_delay");
    endtask

    task automatic test_random_stall();
        for (int i = 0; i < 6; i++) begin
            ax_chan_t a = rand_ax(BURST_INCR, 4'b0010);
            run_burst(a, 8'($urandom_range(0, 7)), $urandom_range(0, 2), 1'b1, 1'b1, -1, "random_stall");
        end
    endtask

    task automatic test_reset_mid_split();
        ax_chan_t a = rand_ax(BURST_INCR, 4'b0010);
        a.len = 8'd15;
        run_burst(a, 8'd3, 0, 1'b0, 1'b0, 1, "rst_mid");
        ax_ready_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        total++;
        if (ax_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid valid_in_reset=%b exp 0", ax_valid_o);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;
        total++;
        if (ax_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid valid_after_reset=%b exp 0", ax_valid_o);
        end
        a = rand_ax(BURST_INCR, 4'b0010);
        run_burst(a, 8'd2, 0, 1'b0, 1'b0, -1, "rst_mid_next");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            burst_t   b = burst_t'($urandom_range(0, 2));
            ax_chan_t a = rand_ax(b, 4'($urandom));
            run_burst(a, 8'($urandom_range(0, 15)), 0, 1'($urandom), 1'b0, -1, "back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_incr_aligned();
        test_incr_unaligned();
        test_no_split();
        test_grant_delay();
        test_random_stall();
        test_reset_mid_split();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
